// File: rtl/decode_cycle_if.sv
// Decode-stage bus: IF/ID inputs, writeback port, stall and the ID/EX pipeline outputs.
interface decode_cycle_if;
  logic [31:0] pc_in;
  logic [31:0] instr_in;
  logic        flush;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        stall;
  logic [31:0] pc_out;
  logic [31:0] rs1_data_out;
  logic [31:0] rs2_data_out;
  logic [31:0] imm_out;
  logic [4:0]  rs1_out;
  logic [4:0]  rs2_out;
  logic [4:0]  rd_out;
  logic [4:0]  alu_op_out;
  logic        alu_src_a_out;
  logic        alu_src_b_out;
  logic        mem_read_out;
  logic        mem_write_out;
  logic [2:0]  mem_size_out;
  logic        reg_write_out;
  logic [1:0]  wb_sel_out;
  logic        branch_out;
  logic        jump_out;
  logic [2:0]  branch_type_out;

  modport master (
    output pc_in, instr_in, flush, wb_en, wb_rd, wb_data,
    input  stall, pc_out, rs1_data_out, rs2_data_out, imm_out, rs1_out, rs2_out, rd_out,
           alu_op_out, alu_src_a_out, alu_src_b_out, mem_read_out, mem_write_out,
           mem_size_out, reg_write_out, wb_sel_out, branch_out, jump_out, branch_type_out
  );

  modport slave (
    input  pc_in, instr_in, flush, wb_en, wb_rd, wb_data,
    output stall, pc_out, rs1_data_out, rs2_data_out, imm_out, rs1_out, rs2_out, rd_out,
           alu_op_out, alu_src_a_out, alu_src_b_out, mem_read_out, mem_write_out,
           mem_size_out, reg_write_out, wb_sel_out, branch_out, jump_out, branch_type_out
  );
endinterface

// File: rtl/decode_cycle.sv
// RV32IM decode stage: register file, control decode, load-use stall and ID/EX register.
// Optional macro DECODE_WB_BYPASS_EN: same-cycle writeback is forwarded to the register reads.
module decode_cycle (
  input  logic          clk,
  input  logic          rst,
  decode_cycle_if.slave bus
);
  localparam logic [6:0] OP_LUI = 7'h37, OP_AUIPC = 7'h17, OP_JAL = 7'h6F, OP_JALR = 7'h67;
  localparam logic [6:0] OP_BR = 7'h63, OP_LOAD = 7'h03, OP_STORE = 7'h23;
  localparam logic [6:0] OP_IMM = 7'h13, OP_REG = 7'h33;
  localparam logic [4:0] ALU_ADD = 5'd0, ALU_SUB = 5'd1, ALU_SLL = 5'd2, ALU_SLT = 5'd3;
  localparam logic [4:0] ALU_SLTU = 5'd4, ALU_XOR = 5'd5, ALU_SRL = 5'd6, ALU_SRA = 5'd7;
  localparam logic [4:0] ALU_OR = 5'd8, ALU_AND = 5'd9, ALU_PASS_B = 5'd10;

  logic [31:0] w_ins;
  logic [6:0]  w_opcode;
  logic [2:0]  w_f3;
  logic [31:0] w_regs [32];

  assign w_ins    = bus.instr_in;
  assign w_opcode = w_ins[6:0];
  assign w_f3     = w_ins[14:12];

  // x0 is hard-wired; entries 1..31 are individual flops so reset can clear them.
  assign w_regs[0] = '0;
  generate
    for (genvar gi = 1; gi < 32; gi++) begin : g_rf
      logic [31:0] r_q;
      always_ff @(posedge clk) begin
        if (rst)
          r_q <= '0;
        else if (bus.wb_en && bus.wb_rd == 5'(gi))
          r_q <= bus.wb_data;
      end
      assign w_regs[gi] = r_q;
    end
  endgenerate

  logic        w_use_rs1, w_use_rs2, w_use_rd;
  logic [4:0]  w_alu_base, w_alu_op;
  logic        w_src_a, w_src_b, w_mem_read, w_mem_write, w_reg_write, w_branch, w_jump;
  logic [1:0]  w_wb_sel;
  logic [2:0]  w_mem_size, w_branch_type;
  logic [31:0] w_imm, w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;

  assign w_imm_i = {{20{w_ins[31]}}, w_ins[31:20]};
  assign w_imm_s = {{20{w_ins[31]}}, w_ins[31:25], w_ins[11:7]};
  assign w_imm_b = {{19{w_ins[31]}}, w_ins[31], w_ins[7], w_ins[30:25], w_ins[11:8], 1'b0};
  assign w_imm_u = {w_ins[31:12], 12'b0};
  assign w_imm_j = {{11{w_ins[31]}}, w_ins[31], w_ins[19:12], w_ins[20], w_ins[30:21], 1'b0};

  // SUB only exists for register-register ops; SRAI/SRA share instr[30].
  always_comb begin
    case (w_f3)
      3'd0:    w_alu_base = (w_opcode == OP_REG && w_ins[30]) ? ALU_SUB : ALU_ADD;
      3'd1:    w_alu_base = ALU_SLL;
      3'd2:    w_alu_base = ALU_SLT;
      3'd3:    w_alu_base = ALU_SLTU;
      3'd4:    w_alu_base = ALU_XOR;
      3'd5:    w_alu_base = w_ins[30] ? ALU_SRA : ALU_SRL;
      3'd6:    w_alu_base = ALU_OR;
      default: w_alu_base = ALU_AND;
    endcase
    if (w_opcode == OP_REG && w_ins[31:25] == 7'h01)
      w_alu_base = {2'b10, w_f3};
  end

  always_comb begin
    w_use_rs1 = 1'b0; w_use_rs2 = 1'b0; w_use_rd = 1'b0;
    w_alu_op = ALU_ADD; w_src_a = 1'b0; w_src_b = 1'b0;
    w_mem_read = 1'b0; w_mem_write = 1'b0; w_mem_size = 3'd0;
    w_reg_write = 1'b0; w_wb_sel = 2'd0;
    w_branch = 1'b0; w_jump = 1'b0; w_branch_type = 3'd0;
    w_imm = '0;
    case (w_opcode)
      OP_REG: begin
        w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; w_use_rd = 1'b1;
        w_alu_op = w_alu_base; w_reg_write = 1'b1;
      end
      OP_IMM: begin
        w_use_rs1 = 1'b1; w_use_rd = 1'b1; w_alu_op = w_alu_base;
        w_src_b = 1'b1; w_reg_write = 1'b1; w_imm = w_imm_i;
      end
      OP_LOAD: begin
        w_use_rs1 = 1'b1; w_use_rd = 1'b1; w_src_b = 1'b1; w_imm = w_imm_i;
        w_mem_read = 1'b1; w_mem_size = w_f3; w_reg_write = 1'b1; w_wb_sel = 2'd1;
      end
      OP_STORE: begin
        w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; w_src_b = 1'b1; w_imm = w_imm_s;
        w_mem_write = 1'b1; w_mem_size = w_f3;
      end
      OP_BR: begin
        w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; w_imm = w_imm_b;
        w_branch = 1'b1; w_branch_type = w_f3;
      end
      OP_JAL: begin
        w_use_rd = 1'b1; w_src_a = 1'b1; w_src_b = 1'b1; w_imm = w_imm_j;
        w_jump = 1'b1; w_reg_write = 1'b1; w_wb_sel = 2'd2;
      end
      OP_JALR: begin
        w_use_rs1 = 1'b1; w_use_rd = 1'b1; w_src_b = 1'b1; w_imm = w_imm_i;
        w_jump = 1'b1; w_reg_write = 1'b1; w_wb_sel = 2'd2;
      end
      OP_LUI: begin
        w_use_rd = 1'b1; w_alu_op = ALU_PASS_B; w_src_b = 1'b1;
        w_imm = w_imm_u; w_reg_write = 1'b1;
      end
      OP_AUIPC: begin
        w_use_rd = 1'b1; w_src_a = 1'b1; w_src_b = 1'b1;
        w_imm = w_imm_u; w_reg_write = 1'b1;
      end
      default: ;
    endcase
  end

  logic [4:0]  w_rs1_idx, w_rs2_idx, w_rd_idx;
  logic [31:0] w_rs1_val, w_rs2_val;
  logic        w_valid;

  assign w_valid   = w_use_rs1 | w_use_rd;
  assign w_rs1_idx = w_use_rs1 ? w_ins[19:15] : 5'd0;
  assign w_rs2_idx = w_use_rs2 ? w_ins[24:20] : 5'd0;
  assign w_rd_idx  = w_use_rd  ? w_ins[11:7]  : 5'd0;

  always_comb begin
    w_rs1_val = w_regs[w_rs1_idx];
    w_rs2_val = w_regs[w_rs2_idx];
`ifdef DECODE_WB_BYPASS_EN
    if (bus.wb_en && bus.wb_rd != 5'd0 && bus.wb_rd == w_rs1_idx) w_rs1_val = bus.wb_data;
    if (bus.wb_en && bus.wb_rd != 5'd0 && bus.wb_rd == w_rs2_idx) w_rs2_val = bus.wb_data;
`endif
  end

  logic [31:0] r_pc, r_rs1_data, r_rs2_data, r_imm;
  logic [4:0]  r_rs1, r_rs2, r_rd, r_alu_op;
  logic        r_src_a, r_src_b, r_mem_read, r_mem_write, r_reg_write, r_branch, r_jump;
  logic [1:0]  r_wb_sel;
  logic [2:0]  r_mem_size, r_branch_type;
  logic        w_stall;

  // Unused index fields are zeroed, so a zero rd never matches them.
  assign w_stall = r_mem_read && (r_rd != 5'd0) &&
                   ((w_rs1_idx == r_rd) || (w_rs2_idx == r_rd));

  // rst, flush and stall all yield an all-zero ID/EX entry.
  always_ff @(posedge clk) begin
    if (rst || bus.flush || w_stall || !w_valid) begin
      r_pc <= '0; r_rs1_data <= '0; r_rs2_data <= '0; r_imm <= '0;
      r_rs1 <= '0; r_rs2 <= '0; r_rd <= '0; r_alu_op <= '0;
      r_src_a <= 1'b0; r_src_b <= 1'b0; r_mem_read <= 1'b0; r_mem_write <= 1'b0;
      r_mem_size <= '0; r_reg_write <= 1'b0; r_wb_sel <= '0;
      r_branch <= 1'b0; r_jump <= 1'b0; r_branch_type <= '0;
    end else begin
      r_pc <= bus.pc_in; r_rs1_data <= w_rs1_val; r_rs2_data <= w_rs2_val; r_imm <= w_imm;
      r_rs1 <= w_rs1_idx; r_rs2 <= w_rs2_idx; r_rd <= w_rd_idx; r_alu_op <= w_alu_op;
      r_src_a <= w_src_a; r_src_b <= w_src_b; r_mem_read <= w_mem_read; r_mem_write <= w_mem_write;
      r_mem_size <= w_mem_size; r_reg_write <= w_reg_write; r_wb_sel <= w_wb_sel;
      r_branch <= w_branch; r_jump <= w_jump; r_branch_type <= w_branch_type;
    end
  end

  assign bus.stall           = w_stall;
  assign bus.pc_out          = r_pc;
  assign bus.rs1_data_out    = r_rs1_data;
  assign bus.rs2_data_out    = r_rs2_data;
  assign bus.imm_out         = r_imm;
  assign bus.rs1_out         = r_rs1;
  assign bus.rs2_out         = r_rs2;
  assign bus.rd_out          = r_rd;
  assign bus.alu_op_out      = r_alu_op;
  assign bus.alu_src_a_out   = r_src_a;
  assign bus.alu_src_b_out   = r_src_b;
  assign bus.mem_read_out    = r_mem_read;
  assign bus.mem_write_out   = r_mem_write;
  assign bus.mem_size_out    = r_mem_size;
  assign bus.reg_write_out   = r_reg_write;
  assign bus.wb_sel_out      = r_wb_sel;
  assign bus.branch_out      = r_branch;
  assign bus.jump_out        = r_jump;
  assign bus.branch_type_out = r_branch_type;
endmodule

// File: tb/tb_decode_cycle.sv
// Bench for decode_cycle: directed literals plus randomized traffic against a reference model.
module tb_decode_cycle;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  decode_cycle_if bus();
  decode_cycle dut (.clk(clk), .rst(rst), .bus(bus));

`ifdef DECODE_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] pc, rs1_data, rs2_data, imm;
    logic [4:0]  rs1, rs2, rd, alu_op;
    logic        src_a, src_b, mem_read, mem_write;
    logic [2:0]  mem_size;
    logic        reg_write;
    logic [1:0]  wb_sel;
    logic        branch, jump;
    logic [2:0]  branch_type;
  } idex_t;

  int checks = 0;
  int errors = 0;
  int txn = 0;
  logic [31:0] m_rf [32];
  idex_t m_q;
  bit    m_init = 0;
  bit    s_stall;
  bit    m_stall;
  // funct3 (plus instr[30] in the upper half) to ALU code
  int unsigned r_tab [16] = '{0, 2, 3, 4, 5, 6, 8, 9, 1, 2, 3, 4, 5, 7, 8, 9};

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] m_read(logic [4:0] idx);
    if (idx == 5'd0) return 32'd0;
    if (BYP && bus.wb_en && bus.wb_rd == idx) return bus.wb_data;
    return m_rf[idx];
  endfunction

  function automatic idex_t m_decode(logic [31:0] ins, logic [31:0] pc);
    idex_t e = '0;
    bit u1 = 0, u2 = 0, ud = 0;
    logic [2:0]  f3 = ins[14:12];
    logic [31:0] sx = 32'($signed(ins) >>> 31);
    logic [31:0] imm_i = 32'($signed(ins) >>> 20);
    logic [31:0] imm_s = (imm_i & ~32'h1F) | {27'd0, ins[11:7]};
    logic [31:0] imm_b = (sx << 12) | (32'(ins[7]) << 11) | (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
    logic [31:0] imm_u = ins & 32'hFFFFF000;
    logic [31:0] imm_j = (sx << 20) | (32'(ins[19:12]) << 12) | (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
    int alu = 0;
    case (ins[6:0])
      7'h33: begin u1 = 1; u2 = 1; ud = 1; e.reg_write = 1;
                   alu = (ins[31:25] == 7'h01) ? 16 + int'(f3) : int'(r_tab[{ins[30], f3}]); end
      7'h13: begin u1 = 1; ud = 1; e.reg_write = 1; e.src_b = 1; e.imm = imm_i;
                   alu = (f3 == 3'd5 && ins[30]) ? 7 : int'(r_tab[{1'b0, f3}]); end
      7'h03: begin u1 = 1; ud = 1; e.reg_write = 1; e.src_b = 1; e.imm = imm_i;
                   e.mem_read = 1; e.mem_size = f3; e.wb_sel = 2'd1; end
      7'h23: begin u1 = 1; u2 = 1; e.src_b = 1; e.imm = imm_s; e.mem_write = 1; e.mem_size = f3; end
      7'h63: begin u1 = 1; u2 = 1; e.imm = imm_b; e.branch = 1; e.branch_type = f3; end
      7'h6F: begin ud = 1; e.src_a = 1; e.src_b = 1; e.imm = imm_j; e.jump = 1;
                   e.reg_write = 1; e.wb_sel = 2'd2; end
      7'h67: begin u1 = 1; ud = 1; e.src_b = 1; e.imm = imm_i; e.jump = 1;
                   e.reg_write = 1; e.wb_sel = 2'd2; end
      7'h37: begin ud = 1; alu = 10; e.src_b = 1; e.imm = imm_u; e.reg_write = 1; end
      7'h17: begin ud = 1; e.src_a = 1; e.src_b = 1; e.imm = imm_u; e.reg_write = 1; end
      default: return '0;
    endcase
    e.alu_op   = 5'(alu);
    e.pc       = pc;
    e.rs1      = u1 ? ins[19:15] : 5'd0;
    e.rs2      = u2 ? ins[24:20] : 5'd0;
    e.rd       = ud ? ins[11:7]  : 5'd0;
    e.rs1_data = m_read(e.rs1);
    e.rs2_data = m_read(e.rs2);
    return e;
  endfunction

  function automatic idex_t dut_view();
    idex_t g;
    g.pc = bus.pc_out; g.rs1_data = bus.rs1_data_out; g.rs2_data = bus.rs2_data_out;
    g.imm = bus.imm_out; g.rs1 = bus.rs1_out; g.rs2 = bus.rs2_out; g.rd = bus.rd_out;
    g.alu_op = bus.alu_op_out; g.src_a = bus.alu_src_a_out; g.src_b = bus.alu_src_b_out;
    g.mem_read = bus.mem_read_out; g.mem_write = bus.mem_write_out; g.mem_size = bus.mem_size_out;
    g.reg_write = bus.reg_write_out; g.wb_sel = bus.wb_sel_out; g.branch = bus.branch_out;
    g.jump = bus.jump_out; g.branch_type = bus.branch_type_out;
    return g;
  endfunction

  // One IF/ID cycle: drive, check stall, advance the model, check ID/EX after the edge.
  task automatic step(input logic r, input logic f, input logic [31:0] ins, input logic [31:0] pc,
                      input logic we, input logic [4:0] wr, input logic [31:0] wd);
    idex_t d, nxt, got;
    rst = r; bus.flush = f; bus.instr_in = ins; bus.pc_in = pc;
    bus.wb_en = we; bus.wb_rd = wr; bus.wb_data = wd;
    #1;
    d = m_decode(ins, pc);
    m_stall = m_init && m_q.mem_read && m_q.rd != 5'd0 && (d.rs1 == m_q.rd || d.rs2 == m_q.rd);
    s_stall = bus.stall;
    if (m_init) chk("stall", {31'd0, bus.stall}, {31'd0, m_stall});
    nxt = (r || f || m_stall) ? '0 : d;
    if (r) begin
      for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
    end else if (we && wr != 5'd0) begin
      m_rf[wr] = wd;
    end
    @(posedge clk); #1;
    m_q = nxt; m_init = 1;
    got = dut_view();
    checks++;
    if (got !== m_q) begin
      errors++;
      $display("FAIL idex txn=%0d actual=%h expected=%h", txn, got, m_q);
    end
    $display("txn %0d rst=%b flush=%b instr=%h stall=%b rd=%0d alu=%0d", txn, r, f, ins, s_stall, bus.rd_out, bus.alu_op_out);
    txn++;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] ins = $urandom;
    logic [6:0]  unk [4] = '{7'h0F, 7'h73, 7'h0B, 7'h7F};
    int k = $urandom_range(0, 9);
    ins[11:7]  = 5'($urandom_range(0, 7));
    ins[19:15] = 5'($urandom_range(0, 7));
    ins[24:20] = 5'($urandom_range(0, 7));
    case (k)
      0: begin
        ins[6:0] = 7'h33;
        case ($urandom_range(0, 2))
          0: ins[31:25] = 7'h00;
          1: ins[31:25] = 7'h01;
          default: begin ins[31:25] = 7'h20; ins[14:12] = ins[12] ? 3'd5 : 3'd0; end
        endcase
      end
      1: begin
        ins[6:0] = 7'h13;
        if (ins[14:12] == 3'd1) ins[31:25] = 7'h00;
        if (ins[14:12] == 3'd5) ins[31:25] = ins[25] ? 7'h20 : 7'h00;
      end
      2: ins[6:0] = 7'h03;
      3: ins[6:0] = 7'h23;
      4: ins[6:0] = 7'h63;
      5: ins[6:0] = 7'h6F;
      6: begin ins[6:0] = 7'h67; ins[14:12] = 3'd0; end
      7: ins[6:0] = 7'h37;
      8: ins[6:0] = 7'h17;
      default: ins[6:0] = unk[$urandom_range(0, 3)];
    endcase
    return ins;
  endfunction

  initial begin
    logic [31:0] cur_ins, cur_pc;
    bit hold;
    bus.flush = 0; bus.instr_in = 0; bus.pc_in = 0; bus.wb_en = 0; bus.wb_rd = 0; bus.wb_data = 0;
    rst = 1;

    step(1, 0, 32'h0, 32'h0, 0, 0, 0);
    step(1, 0, 32'h00500093, 32'h100, 1, 1, 32'h5);
    chk("rst_pc", bus.pc_out, 0);
    chk("rst_regwrite", {31'd0, bus.reg_write_out}, 0);
    chk("rst_imm", bus.imm_out, 0);

    step(0, 0, 32'h00500093, 32'h100, 1, 1, 32'h5);
    chk("addi_rd", {27'd0, bus.rd_out}, 1);
    chk("addi_imm", bus.imm_out, 5);
    chk("addi_alu", {27'd0, bus.alu_op_out}, 0);
    chk("addi_srcb", {31'd0, bus.alu_src_b_out}, 1);
    chk("addi_rw", {31'd0, bus.reg_write_out}, 1);
    chk("addi_pc", bus.pc_out, 32'h100);

    step(0, 0, 32'hFFF00293, 32'h104, 0, 0, 0);
    chk("neg_imm", bus.imm_out, 32'hFFFFFFFF);
    chk("neg_rs1data", bus.rs1_data_out, 0);

    step(0, 0, 32'h0000A103, 32'h108, 0, 0, 0);
    chk("lw_rs1data", bus.rs1_data_out, 5);
    chk("lw_memread", {31'd0, bus.mem_read_out}, 1);
    step(0, 0, 32'h001101B3, 32'h10C, 0, 0, 0);
    chk("lu_stall", {31'd0, s_stall}, 1);
    chk("lu_bubble_rw", {31'd0, bus.reg_write_out}, 0);
    chk("lu_bubble_mr", {31'd0, bus.mem_read_out}, 0);
    step(0, 0, 32'h001101B3, 32'h10C, 0, 0, 0);
    chk("lu_stall_once", {31'd0, s_stall}, 0);
    chk("add_rs1", {27'd0, bus.rs1_out}, 2);
    chk("add_rs2", {27'd0, bus.rs2_out}, 1);
    chk("add_wbsel", {30'd0, bus.wb_sel_out}, 0);
    chk("add_rw", {31'd0, bus.reg_write_out}, 1);

    step(0, 0, 32'h02108233, 32'h110, 0, 0, 0);
    chk("mul_alu", {27'd0, bus.alu_op_out}, 16);
    chk("mul_rs1data", bus.rs1_data_out, 5);
    chk("mul_rs2data", bus.rs2_data_out, 5);

    step(0, 1, 32'h00500093, 32'h114, 0, 0, 0);
    chk("flush_rw", {31'd0, bus.reg_write_out}, 0);
    chk("flush_mr", {31'd0, bus.mem_read_out}, 0);
    chk("flush_jump", {31'd0, bus.jump_out}, 0);

    step(0, 0, 32'h00008013, 32'h118, 1, 1, 32'hA5A5A5A5);
    chk("wb_same_cycle", bus.rs1_data_out, BYP ? 32'hA5A5A5A5 : 32'h5);
    step(0, 0, 32'h00008013, 32'h11C, 0, 0, 0);
    chk("wb_next_cycle", bus.rs1_data_out, 32'hA5A5A5A5);

    step(0, 0, 32'h00000033, 32'h120, 1, 0, 32'h12345678);
    chk("x0_same", bus.rs1_data_out, 0);
    step(0, 0, 32'h00000033, 32'h124, 0, 0, 0);
    chk("x0_after", bus.rs2_data_out, 0);

    step(0, 0, 32'h0000A103, 32'h128, 0, 0, 0);
    step(0, 1, 32'h001101B3, 32'h12C, 0, 0, 0);
    chk("flush_stall", {31'd0, s_stall}, 1);
    chk("flush_stall_bubble", {31'd0, bus.reg_write_out}, 0);

    step(0, 0, 32'h0000A103, 32'h130, 0, 0, 0);
    step(1, 0, 32'h001101B3, 32'h134, 0, 0, 0);
    step(0, 0, 32'h001101B3, 32'h134, 0, 0, 0);
    chk("stall_after_rst", {31'd0, s_stall}, 0);
    chk("rf_cleared", bus.rs2_data_out, 0);

    hold = 0; cur_ins = 0; cur_pc = 0;
    for (int i = 0; i < 1500; i++) begin
      logic r, f;
      if (!hold) begin
        cur_ins = rand_instr();
        cur_pc = $urandom & 32'hFFFFFFFC;
      end
      r = ($urandom_range(0, 199) == 0);
      f = ($urandom_range(0, 9) == 0);
      step(r, f, cur_ins, cur_pc, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
      hold = m_stall && !f && !r;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
